// File: rtl/filter_bank_sequencer_pkg.sv
// Shared types and helpers for the three-channel filter bank sequencer.
// Channel indices are 0..2 for filters yk1..yk3.
package filter_bank_sequencer_pkg;

   localparam int unsigned N              = 16;
   localparam int unsigned TimeoutDefault = 255;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLaunch = 2'd1,
      StWait   = 2'd2,
      StSum    = 2'd3
   } state_e;

   function automatic logic [1:0] first_ch(input logic [2:0] en);
      if (en[0]) begin
         return 2'd0;
      end else if (en[1]) begin
         return 2'd1;
      end
      return 2'd2;
   endfunction

   // Channels strictly after ch, used to find the next enabled channel.
   function automatic logic [2:0] above_mask(input logic [1:0] ch);
      case (ch)
         2'd0:    return 3'b110;
         2'd1:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/filter_bank_sequencer_if.sv
// Sample/channel handshake bundle between the sequencer, the three filters
// and the output stage.
interface filter_bank_sequencer_if #(
   parameter int unsigned W = filter_bank_sequencer_pkg::N
);
   logic                sample_tick;
   logic                sw1, sw2, sw3;
   logic                done1, done2, done3;
   logic signed [W-1:0] yk1, yk2, yk3;
   logic                clr_err;
   logic                start1, start2, start3;
   logic signed [W-1:0] result;
   logic                result_valid;
   logic                busy;
   logic                overrun;
   logic [2:0]          timeout_err;

   modport slave (
      input  sample_tick, sw1, sw2, sw3, done1, done2, done3, yk1, yk2, yk3, clr_err,
      output start1, start2, start3, result, result_valid, busy, overrun, timeout_err
   );

   modport master (
      output sample_tick, sw1, sw2, sw3, done1, done2, done3, yk1, yk2, yk3, clr_err,
      input  start1, start2, start3, result, result_valid, busy, overrun, timeout_err
   );
endinterface

// File: rtl/filter_bank_sequencer_sat_add_signed.sv
// Accumulate a sign-extended W-bit term into a W+2-bit accumulator, and reduce the
// accumulator to W bits either by saturation (SAT=1) or by wrapping (SAT=0).
module filter_bank_sequencer_sat_add_signed #(
   parameter int unsigned W   = 16,
   parameter bit          SAT = 1'b1
) (
   input  logic signed [W+1:0] i_acc,
   input  logic signed [W-1:0] i_term,
   output logic signed [W+1:0] o_sum,
   output logic signed [W-1:0] o_res
);

   localparam logic signed [W+1:0] MaxVal = {3'b000, {(W-1){1'b1}}};
   localparam logic signed [W+1:0] MinVal = {3'b111, {(W-1){1'b0}}};

   logic signed [W+1:0] w_term_ext;

   assign w_term_ext = {{2{i_term[W-1]}}, i_term};
   assign o_sum      = i_acc + w_term_ext;

   always_comb begin
      o_res = i_acc[W-1:0];
      if (SAT) begin
         if (i_acc > MaxVal) begin
            o_res = MaxVal[W-1:0];
         end else if (i_acc < MinVal) begin
            o_res = MinVal[W-1:0];
         end
      end
   end

endmodule

// File: rtl/filter_bank_sequencer.sv
// Per-sample sequencer: starts each enabled filter channel in turn so they can share
// one multiplier, then sums their outputs into a registered, strobed result.
module filter_bank_sequencer
   import filter_bank_sequencer_pkg::*;
#(
   parameter int unsigned W       = N,
   parameter int unsigned TIMEOUT = TimeoutDefault,
   parameter bit          SAT     = 1'b1
) (
   input logic                     clk,
   input logic                     reset,
   filter_bank_sequencer_if.slave  bus
);

   localparam logic [7:0] TimerLimit = 8'(TIMEOUT - 1);

   state_e              r_state, w_state_next;
   logic [1:0]          r_ch, w_ch_next;
   logic [2:0]          r_en;
   logic signed [W+1:0] r_acc;
   logic [7:0]          r_timer;
   logic [2:0]          r_start;
   logic signed [W-1:0] r_result;
   logic                r_result_valid;
   logic                r_busy;
   logic                r_overrun;
   logic [2:0]          r_timeout_err;

   logic [2:0]          w_sw, w_done, w_rem;
   logic signed [W-1:0] w_yk_sel, w_sat;
   logic signed [W+1:0] w_acc_sum;
   logic                w_accept, w_hit, w_timeout;

   assign w_sw     = {bus.sw3, bus.sw2, bus.sw1};
   assign w_done   = {bus.done3, bus.done2, bus.done1};
   assign w_rem    = r_en & above_mask(r_ch);
   assign w_accept = (r_state == StIdle) && bus.sample_tick;
   // Only the channel being awaited is looked at; a done on the limit cycle wins.
   assign w_hit     = (r_state == StWait) && w_done[r_ch];
   assign w_timeout = (r_state == StWait) && !w_done[r_ch] && (r_timer == TimerLimit);

   always_comb begin
      case (r_ch)
         2'd0:    w_yk_sel = bus.yk1;
         2'd1:    w_yk_sel = bus.yk2;
         default: w_yk_sel = bus.yk3;
      endcase
   end

   filter_bank_sequencer_sat_add_signed #(
      .W   (W),
      .SAT (SAT)
   ) u_sat_add (
      .i_acc  (r_acc),
      .i_term (w_yk_sel),
      .o_sum  (w_acc_sum),
      .o_res  (w_sat)
   );

   always_comb begin
      w_state_next = r_state;
      w_ch_next    = r_ch;
      case (r_state)
         StIdle: begin
            if (bus.sample_tick) begin
               if (|w_sw) begin
                  w_state_next = StLaunch;
                  w_ch_next    = first_ch(w_sw);
               end else begin
                  w_state_next = StSum;
               end
            end
         end
         StLaunch: w_state_next = StWait;
         StWait: begin
            if (w_hit || w_timeout) begin
               if (|w_rem) begin
                  w_state_next = StLaunch;
                  w_ch_next    = first_ch(w_rem);
               end else begin
                  w_state_next = StSum;
               end
            end
         end
         StSum:   w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= StIdle;
         r_ch    <= 2'd0;
      end else begin
         r_state <= w_state_next;
         r_ch    <= w_ch_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_en           <= 3'b000;
         r_acc          <= '0;
         r_timer        <= 8'd0;
         r_start        <= 3'b000;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
         r_overrun      <= 1'b0;
         r_timeout_err  <= 3'b000;
      end else begin
         if (w_accept) begin
            r_en  <= w_sw;
            r_acc <= '0;
         end else if (w_hit) begin
            r_acc <= w_acc_sum;
         end

         if (r_state == StLaunch) begin
            r_timer <= 8'd0;
         end else if ((r_state == StWait) && !w_hit && !w_timeout) begin
            r_timer <= r_timer + 8'd1;
         end

         r_start        <= (r_state == StLaunch) ? (3'b001 << r_ch) : 3'b000;
         r_result_valid <= (r_state == StSum);
         if (r_state == StSum) begin
            r_result <= w_sat;
         end

         // A tick landing on the strobe cycle restarts busy before it can drop.
         if (w_accept) begin
            r_busy <= 1'b1;
         end else if (r_result_valid) begin
            r_busy <= 1'b0;
         end

         if (bus.sample_tick && (r_state != StIdle)) begin
            r_overrun <= 1'b1;
         end else if (bus.clr_err) begin
            r_overrun <= 1'b0;
         end

         r_timeout_err <= (bus.clr_err ? 3'b000 : r_timeout_err) |
                          (w_timeout ? (3'b001 << r_ch) : 3'b000);
      end
   end

   assign bus.start1       = r_start[0];
   assign bus.start2       = r_start[1];
   assign bus.start3       = r_start[2];
   assign bus.result       = r_result;
   assign bus.result_valid = r_result_valid;
   assign bus.busy         = r_busy;
   assign bus.overrun      = r_overrun;
   assign bus.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_filter_bank_sequencer.sv
// Directed bench for filter_bank_sequencer: a saturating and a wrapping instance
// share one stimulus stream; a responder model answers each start pulse.
module tb_filter_bank_sequencer;

   localparam int unsigned W = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   filter_bank_sequencer_if #(.W(W)) u_if ();
   filter_bank_sequencer_if #(.W(W)) u_if_wrap ();

   filter_bank_sequencer #(.W(W), .TIMEOUT(8), .SAT(1'b1)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   filter_bank_sequencer #(.W(W), .TIMEOUT(8), .SAT(1'b0)) u_dut_wrap (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if_wrap.slave)
   );

   logic [2:0] done_v = 3'b000;
   assign u_if.done1 = done_v[0];
   assign u_if.done2 = done_v[1];
   assign u_if.done3 = done_v[2];

   assign u_if_wrap.sample_tick = u_if.sample_tick;
   assign u_if_wrap.sw1         = u_if.sw1;
   assign u_if_wrap.sw2         = u_if.sw2;
   assign u_if_wrap.sw3         = u_if.sw3;
   assign u_if_wrap.done1       = done_v[0];
   assign u_if_wrap.done2       = done_v[1];
   assign u_if_wrap.done3       = done_v[2];
   assign u_if_wrap.yk1         = u_if.yk1;
   assign u_if_wrap.yk2         = u_if.yk2;
   assign u_if_wrap.yk3         = u_if.yk3;
   assign u_if_wrap.clr_err     = u_if.clr_err;

   int checks = 0;
   int errors = 0;
   int dly [3];
   int lat, res, res_wrap, order, nstarts, busy_at_tick, n, seen;
   logic [2:0] resp_st;
   int resp_k;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Filter model: done_k pulses dly[k] cycles after start_k; dly 0 = never answers.
   initial forever begin
      @(posedge clk);
      #1;
      resp_st = {u_if.start3, u_if.start2, u_if.start1};
      if (resp_st != 3'b000) begin
         resp_k = resp_st[0] ? 0 : (resp_st[1] ? 1 : 2);
         if (dly[resp_k] > 0) begin
            repeat (dly[resp_k]) @(posedge clk);
            #1;
            done_v[resp_k] = 1'b1;
            @(posedge clk);
            #1;
            done_v[resp_k] = 1'b0;
         end
      end
   end

   // One sample: tick, then count cycles until result_valid; inj = cycle of a stray tick.
   task automatic run(input logic [2:0] sw, input int y1, input int y2, input int y3,
                      input int d1, input int d2, input int d3, input int inj);
      dly[0] = d1;
      dly[1] = d2;
      dly[2] = d3;
      {u_if.sw3, u_if.sw2, u_if.sw1} = sw;
      u_if.yk1 = 16'(y1);
      u_if.yk2 = 16'(y2);
      u_if.yk3 = 16'(y3);
      @(negedge clk);
      busy_at_tick = int'(u_if.busy);
      u_if.sample_tick = 1'b1;
      @(negedge clk);
      u_if.sample_tick = 1'b0;
      lat     = 1;
      order   = 0;
      nstarts = 0;
      while (!u_if.result_valid && lat < 100) begin
         if (u_if.start1 || u_if.start2 || u_if.start3) begin
            order = order * 4 + (u_if.start1 ? 1 : (u_if.start2 ? 2 : 3));
            nstarts++;
         end
         if (lat == inj) begin
            u_if.sample_tick = 1'b1;
            {u_if.sw3, u_if.sw2, u_if.sw1} = ~sw;
         end else begin
            u_if.sample_tick = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      u_if.sample_tick = 1'b0;
      res      = int'($signed(u_if.result));
      res_wrap = int'($signed(u_if_wrap.result));
   endtask

   task automatic clear_errors();
      @(negedge clk);
      u_if.clr_err = 1'b1;
      @(negedge clk);
      u_if.clr_err = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      dly[0] = 3;
      dly[1] = 3;
      dly[2] = 3;
      u_if.sample_tick = 1'b0;
      {u_if.sw3, u_if.sw2, u_if.sw1} = 3'b000;
      u_if.yk1 = '0;
      u_if.yk2 = '0;
      u_if.yk3 = '0;
      u_if.clr_err = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_result", int'(u_if.result), 0);
      check("rst_valid", int'(u_if.result_valid), 0);
      check("rst_busy", int'(u_if.busy), 0);
      check("rst_overrun", int'(u_if.overrun), 0);
      check("rst_timeout", int'(u_if.timeout_err), 0);
      check("rst_starts", int'({u_if.start3, u_if.start2, u_if.start1}), 0);
      reset = 1'b1;
      @(negedge clk);

      // All three channels, 3-cycle filters.
      run(3'b111, 100, 200, -50, 3, 3, 3, -1);
      check("t1_latency", lat, 17);
      check("t1_result", res, 250);
      check("t1_result_wrap", res_wrap, 250);
      check("t1_order", order, 27);
      check("t1_nstarts", nstarts, 3);
      check("t1_busy_at_valid", int'(u_if.busy), 1);
      @(negedge clk);
      check("t1_valid_one_cycle", int'(u_if.result_valid), 0);
      check("t1_busy_dropped", int'(u_if.busy), 0);
      check("t1_result_held", int'($signed(u_if.result)), 250);

      run(3'b101, 10, 999, 20, 2, 2, 2, -1);
      check("t2a_latency", lat, 10);
      check("t2a_result", res, 30);
      check("t2a_order", order, 7);
      check("t2a_nstarts", nstarts, 2);

      // Back-to-back: tick in the cycle right after result_valid.
      run(3'b000, 5, 5, 5, 2, 2, 2, -1);
      check("t2b_busy_at_tick", busy_at_tick, 0);
      check("t2b_latency", lat, 2);
      check("t2b_result", res, 0);
      check("t2b_nstarts", nstarts, 0);
      check("t2b_overrun", int'(u_if.overrun), 0);

      run(3'b111, 32767, 32767, 32767, 1, 1, 1, -1);
      check("t3a_latency", lat, 11);
      check("t3a_result_sat", res, 32767);
      check("t3a_result_wrap", res_wrap, 32765);

      run(3'b111, -32768, -32768, -32768, 1, 1, 1, -1);
      check("t3b_result_sat", res, -32768);
      check("t3b_result_wrap", res_wrap, -32768);

      // Channel 2 never answers.
      run(3'b111, 5, 7, 9, 2, 0, 2, -1);
      check("t4_latency", lat, 19);
      check("t4_result", res, 14);
      check("t4_timeout_err", int'(u_if.timeout_err), 2);
      clear_errors();
      check("t4_timeout_cleared", int'(u_if.timeout_err), 0);

      // done arrives exactly on the timeout limit cycle.
      run(3'b010, 0, 123, 0, 1, 7, 1, -1);
      check("t4b_latency", lat, 11);
      check("t4b_result", res, 123);
      check("t4b_order", order, 2);
      check("t4b_timeout_err", int'(u_if.timeout_err), 0);

      // Tick in the SUM cycle of an all-disabled sample.
      run(3'b000, 1, 1, 1, 1, 1, 1, 1);
      check("t5a_latency", lat, 2);
      check("t5a_overrun", int'(u_if.overrun), 1);
      check("t5a_nstarts", nstarts, 0);
      clear_errors();
      check("t5a_overrun_cleared", int'(u_if.overrun), 0);

      // Stray tick plus sw flip mid-sequence.
      run(3'b111, 1, 2, 3, 3, 3, 3, 5);
      check("t5b_latency", lat, 17);
      check("t5b_result", res, 6);
      check("t5b_nstarts", nstarts, 3);
      check("t5b_overrun", int'(u_if.overrun), 1);
      clear_errors();
      check("t5b_overrun_cleared", int'(u_if.overrun), 0);

      // Reset while waiting on channel 2.
      dly[0] = 2;
      dly[1] = 0;
      dly[2] = 2;
      {u_if.sw3, u_if.sw2, u_if.sw1} = 3'b111;
      u_if.yk1 = 16'(100);
      u_if.yk2 = 16'(200);
      u_if.yk3 = 16'(-50);
      @(negedge clk);
      u_if.sample_tick = 1'b1;
      @(negedge clk);
      u_if.sample_tick = 1'b0;
      n = 0;
      while (!u_if.start2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t6_start2_seen", int'(n < 50), 1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("t6_rst_result", int'(u_if.result), 0);
      check("t6_rst_busy", int'(u_if.busy), 0);
      check("t6_rst_valid", int'(u_if.result_valid), 0);
      check("t6_rst_starts", int'({u_if.start3, u_if.start2, u_if.start1}), 0);
      check("t6_rst_timeout", int'(u_if.timeout_err), 0);
      reset = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (u_if.result_valid || u_if.start1 || u_if.start2 || u_if.start3) seen++;
      end
      check("t6_quiet_after_reset", seen, 0);

      run(3'b111, 100, 200, -50, 3, 3, 3, -1);
      check("t6_rerun_latency", lat, 17);
      check("t6_rerun_result", res, 250);
      check("t6_rerun_order", order, 27);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
